// File: rtl/rv_core_pkg.sv
// rv_core_pkg: shared core constants, requester ids and register index type.
package rv_core_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_LSU = 1'b1;
    typedef logic [AW-1:0] reg_idx_t;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: pending-write bit per register with set-over-clear priority and RAW hazard lookup.
module wb_scoreboard
    import rv_core_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_set_valid,
    input  logic [AW-1:0] i_set_rd,
    input  logic          i_clr_valid,
    input  logic [AW-1:0] i_clr_rd,
    input  logic [AW-1:0] i_rs1,
    input  logic [AW-1:0] i_rs2,
    output logic          o_hazard
);
    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_next;

    // Set is applied after clear so a younger issue keeps ownership of the register.
    always_comb begin
        w_next = r_pending;
        if (i_clr_valid) w_next[i_clr_rd] = 1'b0;
        if (i_set_valid && i_set_rd != '0) w_next[i_set_rd] = 1'b1;
        w_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pending <= '0;
        else     r_pending <= w_next;
    end

    assign o_hazard = (i_rs1 != '0 && r_pending[i_rs1]) || (i_rs2 != '0 && r_pending[i_rs2]);
endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: round-robin arbitration of ALU/LSU writebacks onto the single registered
// register-bank write port, plus pending-write scoreboard for decode hazards.
module reg_wb_arbiter
    import rv_core_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_wb_valid,
    input  logic [AW-1:0]   alu_wb_rd,
    input  logic [XLEN-1:0] alu_wb_data,
    output logic            alu_wb_ready,
    input  logic            lsu_wb_valid,
    input  logic [AW-1:0]   lsu_wb_rd,
    input  logic [XLEN-1:0] lsu_wb_data,
    output logic            lsu_wb_ready,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   dec_rs1,
    input  logic [AW-1:0]   dec_rs2,
    output logic            hazard,
    output logic            RegWrite,
    output logic [AW-1:0]   write_reg,
    output logic [XLEN-1:0] write_data
);
    logic            r_rr;
    logic            r_we;
    reg_idx_t        r_wreg;
    logic [XLEN-1:0] r_wdata;
    logic            w_acc;
    reg_idx_t        w_rd;
    logic [XLEN-1:0] w_data;

    // rr_ptr only matters when both request; a lone requester always wins.
    assign alu_wb_ready = !rst && alu_wb_valid && (!lsu_wb_valid || r_rr == REQ_ALU);
    assign lsu_wb_ready = !rst && lsu_wb_valid && (!alu_wb_valid || r_rr == REQ_LSU);
    assign w_acc  = alu_wb_ready || lsu_wb_ready;
    assign w_rd   = alu_wb_ready ? alu_wb_rd : lsu_wb_rd;
    assign w_data = alu_wb_ready ? alu_wb_data : lsu_wb_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr    <= REQ_ALU;
            r_we    <= 1'b0;
            r_wreg  <= '0;
            r_wdata <= '0;
        end else begin
            if (alu_wb_valid && lsu_wb_valid) r_rr <= ~r_rr;
            r_we <= w_acc && w_rd != '0;
            if (w_acc) begin
                r_wreg  <= w_rd;
                r_wdata <= w_data;
            end
        end
    end

    assign RegWrite   = r_we;
    assign write_reg  = r_wreg;
    assign write_data = r_wdata;

    wb_scoreboard u_sb (
        .clk         (clk),
        .rst         (rst),
        .i_set_valid (iss_valid),
        .i_set_rd    (iss_rd),
        .i_clr_valid (w_acc),
        .i_clr_rd    (w_rd),
        .i_rs1       (dec_rs1),
        .i_rs2       (dec_rs2),
        .o_hazard    (hazard)
    );
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed checks of arbitration, write port, scoreboard and async reset.
module tb_reg_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_wb_valid, lsu_wb_valid, iss_valid;
    logic [4:0]  alu_wb_rd, lsu_wb_rd, iss_rd, dec_rs1, dec_rs2;
    logic [31:0] alu_wb_data, lsu_wb_data;
    logic        alu_wb_ready, lsu_wb_ready, hazard, RegWrite;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    int          errors = 0;
    int          checks = 0;

    reg_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data), .alu_wb_ready(alu_wb_ready),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data), .lsu_wb_ready(lsu_wb_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .hazard(hazard),
        .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        alu_wb_valid = 1'b1; lsu_wb_valid = 1'b0; iss_valid = 1'b0;
        alu_wb_rd = 5'd0; lsu_wb_rd = 5'd0; iss_rd = 5'd0;
        alu_wb_data = '0; lsu_wb_data = '0;
        dec_rs1 = 5'd5; dec_rs2 = 5'd6;
        #12;
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_write_reg", 32'(write_reg), 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_hazard", 32'(hazard), 32'd0);
        chk("rst_alu_ready_forced", 32'(alu_wb_ready), 32'd0);
        alu_wb_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        // ALU-only write
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'h1234;
        #1;
        chk("alu_only_ready", 32'(alu_wb_ready), 32'd1);
        chk("alu_only_lsu_ready", 32'(lsu_wb_ready), 32'd0);
        tick();
        alu_wb_valid = 1'b0;
        chk("alu_only_we", 32'(RegWrite), 32'd1);
        chk("alu_only_reg", 32'(write_reg), 32'd5);
        chk("alu_only_data", write_data, 32'h1234);
        tick();
        chk("alu_only_we_drop", 32'(RegWrite), 32'd0);
        chk("alu_only_reg_hold", 32'(write_reg), 32'd5);
        // round robin: ALU, LSU, ALU
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd3; alu_wb_data = 32'hA3;
        lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd4; lsu_wb_data = 32'hB4;
        #1;
        chk("rr0_alu_ready", 32'(alu_wb_ready), 32'd1);
        chk("rr0_lsu_ready", 32'(lsu_wb_ready), 32'd0);
        tick();
        chk("rr0_reg", 32'(write_reg), 32'd3);
        chk("rr0_data", write_data, 32'hA3);
        chk("rr1_alu_ready", 32'(alu_wb_ready), 32'd0);
        chk("rr1_lsu_ready", 32'(lsu_wb_ready), 32'd1);
        tick();
        chk("rr1_we", 32'(RegWrite), 32'd1);
        chk("rr1_reg", 32'(write_reg), 32'd4);
        chk("rr1_data", write_data, 32'hB4);
        chk("rr2_alu_ready", 32'(alu_wb_ready), 32'd1);
        chk("rr2_lsu_ready", 32'(lsu_wb_ready), 32'd0);
        tick();
        alu_wb_valid = 1'b0; lsu_wb_valid = 1'b0;
        chk("rr2_reg", 32'(write_reg), 32'd3);
        tick();
        chk("rr_idle_we", 32'(RegWrite), 32'd0);
        // scoreboard hazard on rd=7
        iss_valid = 1'b1; iss_rd = 5'd7; dec_rs1 = 5'd0; dec_rs2 = 5'd0;
        tick();
        iss_valid = 1'b0; dec_rs2 = 5'd7;
        #1;
        chk("sb_hazard_rs2", 32'(hazard), 32'd1);
        dec_rs1 = 5'd0; dec_rs2 = 5'd0;
        #1;
        chk("sb_rs0_no_hazard", 32'(hazard), 32'd0);
        dec_rs2 = 5'd7;
        lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd7; lsu_wb_data = 32'h77;
        #1;
        chk("sb_lsu_ready", 32'(lsu_wb_ready), 32'd1);
        chk("sb_hazard_before_accept", 32'(hazard), 32'd1);
        tick();
        lsu_wb_valid = 1'b0;
        chk("sb_hazard_cleared", 32'(hazard), 32'd0);
        chk("sb_lsu_we", 32'(RegWrite), 32'd1);
        chk("sb_lsu_reg", 32'(write_reg), 32'd7);
        chk("sb_lsu_data", write_data, 32'h77);
        // set/clear collision on rd=9
        dec_rs1 = 5'd9; dec_rs2 = 5'd0;
        iss_valid = 1'b1; iss_rd = 5'd9;
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd9; alu_wb_data = 32'h99;
        #1;
        chk("col_hazard_before", 32'(hazard), 32'd0);
        tick();
        iss_valid = 1'b0; alu_wb_valid = 1'b0;
        chk("col_set_wins", 32'(hazard), 32'd1);
        chk("col_reg", 32'(write_reg), 32'd9);
        tick();
        chk("col_hazard_stays", 32'(hazard), 32'd1);
        // write to x0
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd0; alu_wb_data = 32'hDEAD;
        #1;
        chk("x0_ready", 32'(alu_wb_ready), 32'd1);
        tick();
        alu_wb_valid = 1'b0;
        chk("x0_no_we", 32'(RegWrite), 32'd0);
        chk("x0_reg", 32'(write_reg), 32'd0);
        chk("x0_data", write_data, 32'hDEAD);
        // async reset while RegWrite=1 and pending[12]=1
        iss_valid = 1'b1; iss_rd = 5'd12;
        tick();
        iss_valid = 1'b0;
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd13; alu_wb_data = 32'h13;
        tick();
        alu_wb_valid = 1'b0; dec_rs1 = 5'd12;
        #1;
        chk("ar_pre_we", 32'(RegWrite), 32'd1);
        chk("ar_pre_hazard", 32'(hazard), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_we_dropped", 32'(RegWrite), 32'd0);
        chk("ar_hazard_dropped", 32'(hazard), 32'd0);
        chk("ar_reg_cleared", 32'(write_reg), 32'd0);
        dec_rs1 = 5'd9;
        #1;
        chk("ar_pending9_dropped", 32'(hazard), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        // rr_ptr was 1 before reset; reset must return it to ALU
        alu_wb_valid = 1'b1; lsu_wb_valid = 1'b1;
        #1;
        chk("ar_rr_alu_ready", 32'(alu_wb_ready), 32'd1);
        chk("ar_rr_lsu_ready", 32'(lsu_wb_ready), 32'd0);
        alu_wb_valid = 1'b0; lsu_wb_valid = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the single write port of the register bank between two writeback requesters: the ALU path (req 0) and the load/store unit (req 1).
- Tracks which destination registers have writes in flight, using a 32-bit pending scoreboard.
- Gives decode a combinational RAW-hazard stall.
- Sits between the execute/memory stages and the register bank; its registered outputs drive RegWrite, write_reg and write_data directly.

Parameters:
- XLEN, 32, data width of write_data and requester data
- NREG, 32, number of architectural registers (x0 hardwired zero)
- AW, 5, register index width, equal to log2(NREG)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- alu_wb_valid  in  1  ALU writeback request
- alu_wb_rd  in  AW  ALU destination register
- alu_wb_data  in  XLEN  ALU result
- alu_wb_ready  out  1  ALU request accepted this cycle
- lsu_wb_valid  in  1  load writeback request
- lsu_wb_rd  in  AW  load destination register
- lsu_wb_data  in  XLEN  load data
- lsu_wb_ready  out  1  load request accepted this cycle
- iss_valid  in  1  decode issues an instruction that will write a register
- iss_rd  in  AW  destination of the issued instruction
- dec_rs1  in  AW  decode source register 1
- dec_rs2  in  AW  decode source register 2
- hazard  out  1  decode must stall: a source register is pending
- RegWrite  out  1  register bank write enable (registered)
- write_reg  out  AW  register bank write index (registered)
- write_data  out  XLEN  register bank write data (registered)

Behaviour:
- Reset (async, rst=1):
  - RegWrite=0, write_reg=0, write_data=0.
  - pending all 0; rr_ptr=0 (ALU favoured).
  - ready outputs follow combinational rules, but are forced 0 while rst=1.
- Handshake:
  - A request transfers at a posedge where valid&ready=1.
  - Once asserted, valid and its rd/data must stay stable until accepted.
  - ready is combinational from both valid inputs and rr_ptr.
  - ready never depends on ready, so there is no loop.
- Arbitration:
  - Only one valid: that requester is granted (ready=1) and rr_ptr is unchanged.
  - Both valid: grant the requester selected by rr_ptr (0=ALU, 1=LSU), and rr_ptr toggles at that edge.
  - Neither valid: both ready=0.
  - At most one ready is high per cycle.
- Write port (latency 1):
  - At an accept edge: RegWrite<=(rd!=0), write_reg<=rd, write_data<=data.
  - At an edge with no accept: RegWrite<=0; write_reg and write_data hold.
  - The bank commits on the following negedge, and a read at the next posedge sees the new value.
  - A write to x0 is accepted (ready=1) but RegWrite stays 0.
- Scoreboard:
  - At an edge with iss_valid=1 and iss_rd!=0: pending[iss_rd]<=1.
  - At an accept edge: pending[accepted rd]<=0.
  - Same register set and cleared at the same edge: the set wins (the younger instruction owns the register).
  - pending[0] is always 0.
  - An accept for a register that is not pending is legal and only clears the bit (no error).
- Hazard:
  - hazard = (dec_rs1!=0 & pending[dec_rs1]) | (dec_rs2!=0 & pending[dec_rs2]).
  - Combinational, no bypass.
  - Because pending clears at the accept edge, decode may read one cycle after the accept and obtain the committed value.
- Reset mid-operation: all in-flight pending bits are discarded, no write is issued, and an output write in progress is cancelled (RegWrite=0 immediately).

Decomposition:
- Shared package `rv_core_pkg`:
  - XLEN, AW and NREG constants.
  - REQ_ALU=0 and REQ_LSU=1 requester-id constants.
  - Register index type reg_idx_t.
- One natural sub-module, `wb_scoreboard`:
  - Contains the pending vector, the set/clear priority logic and the hazard lookup.
  - The top level holds the round-robin arbiter and the output register.

Test Plan:
- After reset: RegWrite=0, write_reg=0, write_data=0, hazard=0 for any rs1/rs2.
- ALU-only write: alu_wb_valid=1, rd=5, data=0x1234 -> alu_wb_ready=1 that cycle; next cycle RegWrite=1, write_reg=5, write_data=0x1234; the cycle after, RegWrite=0.
- Conflict round-robin: both valid for 3 consecutive cycles from reset (ALU rd=3, LSU rd=4) -> grant sequence ALU, LSU, ALU; RegWrite pulses write_reg 3, 4, 3; ready never high on both at once.
- Scoreboard hazard:
  - iss_valid with rd=7, then dec_rs2=7 -> hazard=1.
  - LSU writeback of rd=7 is accepted -> hazard=0 in the following cycle.
  - dec_rs1=0 never raises hazard.
- Set/clear collision: ALU accept of rd=9 at the same edge as iss_valid with rd=9 -> pending[9]=1 afterwards, and hazard stays 1 for rs1=9.
- x0 and async reset:
  - ALU write to rd=0 -> ready=1, RegWrite stays 0.
  - Asserting rst between clock edges while RegWrite=1 and pending[12]=1 -> RegWrite=0 and hazard for rs1=12 drops immediately.
